// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline front-end control: sequencer states,
// the hazard-free register index, the fetch stride and the NOP used by IF/ID flushes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } seq_state_e;

    localparam int XZR_IDX_C     = 31;
    localparam int INSTR_BYTES_C = 4;

    // Canonical A64 NOP encoding that the IF/ID register loads when flushed.
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clear has priority, inc adds one until all ones, then holds.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Front-end sequencer for the 5-stage LEGv8 pipeline: chooses PC advance/hold/redirect,
// drives IF/ID, ID/EX and EX/MEM bubble controls, and keeps saturating perf counters.
module pc_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_BYTES = INSTR_BYTES_C,
    parameter int CNT_WIDTH   = 16,
    parameter int XZR_IDX     = XZR_IDX_C
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  current_pc,
    input  logic                 imem_ready,
    input  logic [4:0]           if_id_rn,
    input  logic [4:0]           if_id_rm,
    input  logic                 if_id_uses_rm,
    input  logic                 id_ex_mem_read,
    input  logic [4:0]           id_ex_rd,
    input  logic                 halt_req,
    input  logic                 branch_taken_mem,
    input  logic [PC_WIDTH-1:0]  branch_target_mem,
    output logic                 PCWrite,
    output logic [PC_WIDTH-1:0]  next_pc,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cyc_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam logic [4:0] XZR_REG = 5'(XZR_IDX);

    seq_state_e          state;
    seq_state_e          state_next;
    logic                load_use;
    logic                stall_inc;
    logic                flush_inc;
    logic [PC_WIDTH-1:0] seq_pc;

    assign seq_pc = current_pc + PC_WIDTH'(INSTR_BYTES);

    assign load_use = id_ex_mem_read && (id_ex_rd != XZR_REG) &&
                      ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        next_pc      = seq_pc;
        PCWrite      = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        halted       = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (reset) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            unique case (state)
                BOOT: begin
                    if_id_flush = 1'b1;
                    state_next  = RUN;
                end
                RUN: begin
                    // A taken branch in MEM squashes everything younger, so it beats any stall.
                    if (branch_taken_mem) begin
                        next_pc      = branch_target_mem;
                        PCWrite      = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else if (halt_req) begin
                        if_id_flush = 1'b1;
                        state_next  = HALT;
                    end else if (!imem_ready) begin
                        if_id_flush = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        PCWrite = 1'b1;
                    end
                end
                HALT: begin
                    if_id_flush = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_cyc_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (1'b1),
        .count (cyc_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a rule-level reference model checked every cycle.
module tb_pc_sequencer;

    localparam int PCW  = 10;
    localparam int CW   = 6;
    localparam int MAXC = (1 << CW) - 1;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic           clk;
    logic           reset;
    logic [PCW-1:0] current_pc;
    logic           imem_ready;
    logic [4:0]     if_id_rn;
    logic [4:0]     if_id_rm;
    logic           if_id_uses_rm;
    logic           id_ex_mem_read;
    logic [4:0]     id_ex_rd;
    logic           halt_req;
    logic           branch_taken_mem;
    logic [PCW-1:0] branch_target_mem;
    logic           PCWrite;
    logic [PCW-1:0] next_pc;
    logic           if_id_write;
    logic           if_id_flush;
    logic           id_ex_flush;
    logic           ex_mem_flush;
    logic           halted;
    logic [CW-1:0]  cyc_cnt;
    logic [CW-1:0]  stall_cnt;
    logic [CW-1:0]  flush_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    int m_mode;
    int m_cyc;
    int m_stall;
    int m_flush;

    pc_sequencer #(
        .PC_WIDTH    (PCW),
        .INSTR_BYTES (4),
        .CNT_WIDTH   (CW),
        .XZR_IDX     (31)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .current_pc        (current_pc),
        .imem_ready        (imem_ready),
        .if_id_rn          (if_id_rn),
        .if_id_rm          (if_id_rm),
        .if_id_uses_rm     (if_id_uses_rm),
        .id_ex_mem_read    (id_ex_mem_read),
        .id_ex_rd          (id_ex_rd),
        .halt_req          (halt_req),
        .branch_taken_mem  (branch_taken_mem),
        .branch_target_mem (branch_target_mem),
        .PCWrite           (PCWrite),
        .next_pc           (next_pc),
        .if_id_write       (if_id_write),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .ex_mem_flush      (ex_mem_flush),
        .halted            (halted),
        .cyc_cnt           (cyc_cnt),
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_lu();
        return id_ex_mem_read && (int'(id_ex_rd) != 31) &&
               ((id_ex_rd == if_id_rn) || (if_id_uses_rm && (id_ex_rd == if_id_rm)));
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Reference state advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            m_mode  <= M_BOOT;
            m_cyc   <= 0;
            m_stall <= 0;
            m_flush <= 0;
        end else begin
            m_cyc <= sat(m_cyc + 1);
            if (m_mode == M_BOOT) begin
                m_mode <= M_RUN;
            end else if (m_mode == M_RUN) begin
                if (branch_taken_mem)      m_flush <= sat(m_flush + 1);
                else if (model_lu())       m_stall <= sat(m_stall + 1);
                else if (halt_req)         m_mode  <= M_HALT;
                else if (!imem_ready)      m_stall <= sat(m_stall + 1);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int e_npc;
        int e_pcw, e_ifw, e_iff, e_idf, e_exf, e_hlt;
        if (chk_en) begin
            e_npc = (int'(current_pc) + 4) % (1 << PCW);
            e_pcw = 0; e_ifw = 1; e_iff = 0; e_idf = 0; e_exf = 0; e_hlt = 0;
            if (reset) begin
                e_ifw = 0; e_iff = 1; e_idf = 1; e_exf = 1;
            end else if (m_mode == M_BOOT) begin
                e_iff = 1;
            end else if (m_mode == M_HALT) begin
                e_iff = 1; e_hlt = 1;
            end else if (branch_taken_mem) begin
                e_npc = int'(branch_target_mem);
                e_pcw = 1; e_iff = 1; e_idf = 1; e_exf = 1;
            end else if (model_lu()) begin
                e_ifw = 0; e_idf = 1;
            end else if (halt_req || !imem_ready) begin
                e_iff = 1;
            end else begin
                e_pcw = 1;
            end
            check("m_next_pc",      32'(next_pc),      32'(e_npc));
            check("m_pcwrite",      32'(PCWrite),      32'(e_pcw));
            check("m_if_id_write",  32'(if_id_write),  32'(e_ifw));
            check("m_if_id_flush",  32'(if_id_flush),  32'(e_iff));
            check("m_id_ex_flush",  32'(id_ex_flush),  32'(e_idf));
            check("m_ex_mem_flush", 32'(ex_mem_flush), 32'(e_exf));
            check("m_halted",       32'(halted),       32'(e_hlt));
            check("m_cyc_cnt",      32'(cyc_cnt),      32'(m_cyc));
            check("m_stall_cnt",    32'(stall_cnt),    32'(m_stall));
            check("m_flush_cnt",    32'(flush_cnt),    32'(m_flush));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; current_pc = '0; imem_ready = 1'b1;
        if_id_rn = '0; if_id_rm = '0; if_id_uses_rm = 1'b0;
        id_ex_mem_read = 1'b0; id_ex_rd = '0; halt_req = 1'b0;
        branch_taken_mem = 1'b0; branch_target_mem = '0;

        next_cycle(); chk_en = 1'b1;
        mid();
        check("rst_pcwrite", 32'(PCWrite), 0);
        check("rst_if_id_write", 32'(if_id_write), 0);
        check("rst_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);
        check("rst_cyc_cnt", 32'(cyc_cnt), 0);

        next_cycle(); reset = 1'b0;
        mid();
        check("boot_pcwrite", 32'(PCWrite), 0);
        check("boot_if_id_flush", 32'(if_id_flush), 1);

        next_cycle(); current_pc = 10'h000;
        mid();
        check("seq0_next_pc", 32'(next_pc), 32'h004);
        check("seq0_pcwrite", 32'(PCWrite), 1);
        check("seq0_cyc", 32'(cyc_cnt), 1);
        next_cycle(); current_pc = 10'h004;
        mid();
        check("seq1_next_pc", 32'(next_pc), 32'h008);
        check("seq1_cyc", 32'(cyc_cnt), 2);
        next_cycle(); current_pc = 10'h008;
        mid();
        check("seq2_next_pc", 32'(next_pc), 32'h00C);
        check("seq2_cyc", 32'(cyc_cnt), 3);

        next_cycle(); current_pc = 10'h3FC;
        mid();
        check("wrap_next_pc", 32'(next_pc), 32'h000);
        check("wrap_pcwrite", 32'(PCWrite), 1);

        next_cycle(); current_pc = 10'h100; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rn = 5'd5;
        mid();
        check("lu_pcwrite", 32'(PCWrite), 0);
        check("lu_if_id_write", 32'(if_id_write), 0);
        check("lu_id_ex_flush", 32'(id_ex_flush), 1);

        next_cycle(); id_ex_rd = 5'd31; if_id_rn = 5'd31;
        mid();
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        check("xzr_pcwrite", 32'(PCWrite), 1);

        next_cycle(); id_ex_rd = 5'd5; if_id_rn = 5'd0; if_id_rm = 5'd5; if_id_uses_rm = 1'b0;
        mid();
        check("rm_unused_pcwrite", 32'(PCWrite), 1);

        next_cycle(); if_id_uses_rm = 1'b1;
        mid();
        check("rm_used_pcwrite", 32'(PCWrite), 0);

        next_cycle(); branch_taken_mem = 1'b1; branch_target_mem = 10'h120; imem_ready = 1'b0;
        mid();
        check("br_next_pc", 32'(next_pc), 32'h120);
        check("br_pcwrite", 32'(PCWrite), 1);
        check("br_flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'h7);

        next_cycle(); branch_taken_mem = 1'b0; id_ex_mem_read = 1'b0; imem_ready = 1'b1; current_pc = 10'h120;
        mid();
        check("br_flush_cnt", 32'(flush_cnt), 1);
        check("br_stall_cnt", 32'(stall_cnt), 2);

        current_pc = 10'h040;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); imem_ready = 1'b0;
            mid();
            check("wait_pcwrite", 32'(PCWrite), 0);
            check("wait_if_id_flush", 32'(if_id_flush), 1);
        end
        next_cycle(); imem_ready = 1'b1;
        mid();
        check("wait_stall_cnt", 32'(stall_cnt), 5);
        check("ready_next_pc", 32'(next_pc), 32'h044);

        next_cycle(); imem_ready = 1'b0;
        repeat (70) next_cycle();
        imem_ready = 1'b1;
        mid();
        check("sat_stall_cnt", 32'(stall_cnt), 63);
        check("sat_cyc_cnt", 32'(cyc_cnt), 63);

        next_cycle(); halt_req = 1'b1; id_ex_mem_read = 1'b1; id_ex_rd = 5'd5; if_id_rn = 5'd5; if_id_uses_rm = 1'b0;
        mid();
        check("hlu_pcwrite", 32'(PCWrite), 0);
        check("hlu_id_ex_flush", 32'(id_ex_flush), 1);
        check("hlu_halted", 32'(halted), 0);

        next_cycle(); id_ex_mem_read = 1'b0;
        mid();
        check("hreq_if_id_flush", 32'(if_id_flush), 1);
        check("hreq_halted", 32'(halted), 0);

        next_cycle(); halt_req = 1'b0; branch_taken_mem = 1'b1; branch_target_mem = 10'h200; imem_ready = 1'b0;
        mid();
        check("halt_halted", 32'(halted), 1);
        check("halt_pcwrite", 32'(PCWrite), 0);
        check("halt_ex_mem_flush", 32'(ex_mem_flush), 0);
        repeat (3) next_cycle();
        mid();
        check("halt_stays", 32'(halted), 1);

        next_cycle(); reset = 1'b1;
        mid();
        check("rst2_halted", 32'(halted), 0);
        check("rst2_pcwrite", 32'(PCWrite), 0);

        next_cycle(); reset = 1'b0; branch_taken_mem = 1'b0; imem_ready = 1'b1; current_pc = 10'h000;
        mid();
        check("rst2_cyc_cnt", 32'(cyc_cnt), 0);
        check("rst2_flush_cnt", 32'(flush_cnt), 0);
        check("rst2_boot_pcwrite", 32'(PCWrite), 0);

        next_cycle();
        mid();
        check("rst2_run_pcwrite", 32'(PCWrite), 1);

        next_cycle(); id_ex_mem_read = 1'b1; id_ex_rd = 5'd3; if_id_rn = 5'd3;
        next_cycle(); reset = 1'b1;
        next_cycle(); reset = 1'b0; id_ex_mem_read = 1'b0;
        mid();
        check("midrst_stall_cnt", 32'(stall_cnt), 0);
        repeat (4) next_cycle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
